// File: rtl/sjr_call_pkg.sv
// Shared types and defaults for the req/busy/return method-call initiator.
package sjr_call_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RUN,
    RSP
  } call_state_t;

  localparam int unsigned DEF_TIMEOUT = 10000;
  localparam int          DEF_CNT_W   = 16;

endpackage

// File: rtl/sjr_call_timer.sv
// Clear/enable cycle counter with a terminal-count flag one cycle before the abort limit.
module sjr_call_timer
  import sjr_call_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int          CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/sjr_method_caller.sv
// Hardware initiator for one req/busy/return method call at a time, with timeout abort
// and a registered valid/ready response carrying return value, status and cycle count.
module sjr_method_caller
  import sjr_call_pkg::*;
#(
  parameter int          ARG_W   = 32,
  parameter int          RET_W   = 1,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int          CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ARG_W-1:0] cmd_arg,
  output logic [ARG_W-1:0] callee_arg,
  output logic             callee_req,
  input  logic             callee_busy,
  input  logic [RET_W-1:0] callee_return,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RET_W-1:0] rsp_ret,
  output logic             rsp_timeout,
  output logic [CNT_W-1:0] rsp_cycles
);

  call_state_t      state, state_d;
  logic [CNT_W-1:0] count;
  logic             tc;

  logic [ARG_W-1:0] callee_arg_d;
  logic             callee_req_d;
  logic             rsp_valid_d;
  logic [RET_W-1:0] rsp_ret_d;
  logic             rsp_timeout_d;
  logic [CNT_W-1:0] rsp_cycles_d;

  assign cmd_ready = (state == IDLE) && !callee_busy;

  sjr_call_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == IDLE),
    .enable ((state == REQ) || (state == RUN)),
    .count  (count),
    .tc     (tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      callee_arg  <= '0;
      callee_req  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_ret     <= '0;
      rsp_timeout <= 1'b0;
      rsp_cycles  <= '0;
    end else begin
      state       <= state_d;
      callee_arg  <= callee_arg_d;
      callee_req  <= callee_req_d;
      rsp_valid   <= rsp_valid_d;
      rsp_ret     <= rsp_ret_d;
      rsp_timeout <= rsp_timeout_d;
      rsp_cycles  <= rsp_cycles_d;
    end
  end

  // Busy sampled on the limit cycle is tested first, so completion beats the abort.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (cmd_valid && cmd_ready) state_d = REQ;
      REQ:     if (callee_busy) state_d = RUN;
               else if (tc)     state_d = RSP;
      RUN:     if (!callee_busy || tc) state_d = RSP;
      RSP:     if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    callee_arg_d  = callee_arg;
    callee_req_d  = callee_req;
    rsp_valid_d   = rsp_valid;
    rsp_ret_d     = rsp_ret;
    rsp_timeout_d = rsp_timeout;
    rsp_cycles_d  = rsp_cycles;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          callee_arg_d = cmd_arg;
          callee_req_d = 1'b1;
        end
      end
      REQ: begin
        if (callee_busy) begin
          callee_req_d = 1'b0;
        end else if (tc) begin
          callee_req_d  = 1'b0;
          rsp_ret_d     = '0;
          rsp_timeout_d = 1'b1;
          rsp_cycles_d  = CNT_W'(TIMEOUT);
          rsp_valid_d   = 1'b1;
        end
      end
      RUN: begin
        if (!callee_busy) begin
          rsp_ret_d     = callee_return;
          rsp_timeout_d = 1'b0;
          rsp_cycles_d  = count + 1'b1;
          rsp_valid_d   = 1'b1;
        end else if (tc) begin
          rsp_ret_d     = '0;
          rsp_timeout_d = 1'b1;
          rsp_cycles_d  = CNT_W'(TIMEOUT);
          rsp_valid_d   = 1'b1;
        end
      end
      RSP: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sjr_method_caller.sv
// Self-checking bench for sjr_method_caller: directed vector table, corner sequences
// and randomized calls against a cycle-count model of the call protocol.
module tb_sjr_method_caller;

  localparam int ARG_W = 32;
  localparam int RET_W = 1;
  localparam int T     = 16;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [ARG_W-1:0] cmd_arg = '0;
  logic [ARG_W-1:0] callee_arg;
  logic             callee_req;
  logic             callee_busy;
  logic [RET_W-1:0] callee_return;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [RET_W-1:0] rsp_ret;
  logic             rsp_timeout;
  logic [CNT_W-1:0] rsp_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sjr_method_caller #(
    .ARG_W   (ARG_W),
    .RET_W   (RET_W),
    .TIMEOUT (T),
    .CNT_W   (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_arg       (cmd_arg),
    .callee_arg    (callee_arg),
    .callee_req    (callee_req),
    .callee_busy   (callee_busy),
    .callee_return (callee_return),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_ret       (rsp_ret),
    .rsp_timeout   (rsp_timeout),
    .rsp_cycles    (rsp_cycles)
  );

  // Stub callee: busy rises stub_d cycles after req is seen, stays high stub_l cycles,
  // return = (arg==3) once busy falls (inverted while busy so early capture shows up).
  int         stub_d = 1, stub_l = 5;
  bit         stub_never = 1'b0;
  logic       force_busy = 1'b0;
  logic       stub_busy = 1'b0;
  logic       stub_ret = 1'b0;
  int         ph = 0, cnt = 0;
  logic [31:0] stub_arg = '0;

  assign callee_busy   = stub_busy | force_busy;
  assign callee_return = stub_ret;

  always @(posedge clk) begin
    case (ph)
      0: if (callee_req && !stub_never) begin
        stub_arg <= callee_arg;
        if (stub_d == 1) begin
          stub_busy <= 1'b1; stub_ret <= !(callee_arg == 3); ph <= 2; cnt <= stub_l - 1;
        end else begin
          ph <= 1; cnt <= stub_d - 2;
        end
      end
      1: if (cnt == 0) begin
        stub_busy <= 1'b1; stub_ret <= !(stub_arg == 3); ph <= 2; cnt <= stub_l - 1;
      end else cnt <= cnt - 1;
      2: if (cnt == 0) begin
        stub_busy <= 1'b0; stub_ret <= (stub_arg == 3); ph <= 3;
      end else cnt <= cnt - 1;
      default: if (!callee_req) ph <= 0;
    endcase
  end

  typedef struct {
    logic [31:0] arg;
    int          d;
    int          l;
    bit          never;
    int          hold;
    logic        exp_ret;
    logic        exp_to;
    int          exp_cyc;
    int          exp_req;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Protocol-level model: busy seen one cycle after it rises, idle seen one cycle after it falls.
  function automatic vec_t model(input logic [31:0] arg, input int d, input int l,
                                 input bit never, input int hold);
    vec_t v;
    int   done;
    v.arg = arg; v.d = d; v.l = l; v.never = never; v.hold = hold;
    if (never) begin
      v.exp_req = T; v.exp_cyc = T; v.exp_to = 1'b1; v.exp_ret = 1'b0;
    end else begin
      v.exp_req = (d + 1 <= T) ? d + 1 : T;
      done = d + l + 1;
      if (done <= T) begin
        v.exp_cyc = done; v.exp_to = 1'b0; v.exp_ret = (arg == 3);
      end else begin
        v.exp_cyc = T; v.exp_to = 1'b1; v.exp_ret = 1'b0;
      end
    end
    return v;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); @(negedge clk); n++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
  endtask

  task automatic run_call(input vec_t v);
    int k, req_n;
    bit arg_ok, stable;
    stub_d = v.d; stub_l = v.l; stub_never = v.never;
    wait_ready();
    cmd_valid = 1'b1; cmd_arg = v.arg;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0; cmd_arg = $urandom;
    k = 0; req_n = 0; arg_ok = 1'b1;
    while (!rsp_valid && k < 100) begin
      if (callee_req) req_n++;
      if (callee_arg != v.arg) arg_ok = 1'b0;
      @(posedge clk); @(negedge clk); k++;
    end
    chk("latency", k, v.exp_cyc);
    chk("req_cycles", req_n, v.exp_req);
    chk("arg_stable_call", arg_ok, 1);
    chk("rsp_ret", rsp_ret, v.exp_ret);
    chk("rsp_timeout", rsp_timeout, v.exp_to);
    chk("rsp_cycles", rsp_cycles, v.exp_cyc);
    chk("req_low_in_rsp", callee_req, 0);
    stable = 1'b1;
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk); @(negedge clk);
      if (!rsp_valid || rsp_ret != v.exp_ret || rsp_timeout != v.exp_to ||
          rsp_cycles != CNT_W'(v.exp_cyc) || cmd_ready || callee_arg != v.arg)
        stable = 1'b0;
    end
    if (v.hold > 0) chk("rsp_hold_stable", stable, 1);
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_cleared", rsp_valid, 0);
    chk("arg_after_rsp", callee_arg, v.arg);
  endtask

  vec_t tbl[5];
  vec_t rv;

  initial begin
    tbl[0] = '{arg: 3, d: 1, l: 5, never: 0, hold: 0,  exp_ret: 1, exp_to: 0, exp_cyc: 7,  exp_req: 2};
    tbl[1] = '{arg: 5, d: 1, l: 5, never: 0, hold: 2,  exp_ret: 0, exp_to: 0, exp_cyc: 7,  exp_req: 2};
    tbl[2] = '{arg: 9, d: 1, l: 5, never: 1, hold: 1,  exp_ret: 0, exp_to: 1, exp_cyc: 16, exp_req: 16};
    tbl[3] = '{arg: 3, d: 2, l: 3, never: 0, hold: 20, exp_ret: 1, exp_to: 0, exp_cyc: 6,  exp_req: 3};
    tbl[4] = '{arg: 3, d: 1, l: 1, never: 0, hold: 0,  exp_ret: 1, exp_to: 0, exp_cyc: 3,  exp_req: 2};

    #3;
    chk("rst_req", callee_req, 0);
    chk("rst_arg", callee_arg, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_ret", rsp_ret, 0);
    chk("rst_timeout", rsp_timeout, 0);
    chk("rst_cycles", rsp_cycles, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_call(tbl[i]);

    // Foreign busy while idle blocks acceptance.
    stub_never = 1'b0; stub_d = 1; stub_l = 2;
    force_busy = 1'b1; cmd_valid = 1'b1; cmd_arg = 3;
    begin
      bit blocked = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); @(negedge clk);
        if (cmd_ready || callee_req) blocked = 1'b0;
      end
      chk("busy_blocks_accept", blocked, 1);
    end
    cmd_valid = 1'b0; force_busy = 1'b0;
    run_call(model(3, 1, 2, 0, 0));

    // Async reset while req is high.
    stub_never = 1'b1;
    wait_ready();
    cmd_valid = 1'b1; cmd_arg = 7;
    @(posedge clk); @(negedge clk); cmd_valid = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("req_before_reset", callee_req, 1);
    #2 reset = 1'b0; #1;
    chk("async_req_drop", callee_req, 0);
    chk("async_arg_clear", callee_arg, 0);
    @(negedge clk); reset = 1'b1; stub_never = 1'b0;

    // Async reset mid-RUN: no response afterwards.
    stub_d = 1; stub_l = 10;
    wait_ready();
    cmd_valid = 1'b1; cmd_arg = 3;
    @(posedge clk); @(negedge clk); cmd_valid = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    chk("in_run_busy", callee_busy, 1);
    #2 reset = 1'b0; #1;
    chk("async_run_req", callee_req, 0);
    chk("async_run_valid", rsp_valid, 0);
    @(negedge clk); reset = 1'b1;
    begin
      bit quiet = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); @(negedge clk);
        if (rsp_valid || callee_req) quiet = 1'b0;
      end
      chk("no_rsp_after_reset", quiet, 1);
    end
    run_call(tbl[0]);

    // Randomized calls, some crossing the timeout limit.
    for (int i = 0; i < 30; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 1) == 1) ? 32'd3 : $urandom;
      rv = model(a, $urandom_range(1, 4), $urandom_range(1, 14),
                 ($urandom_range(0, 9) == 0), $urandom_range(0, 3));
      run_call(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
